// File: rtl/wave_key_ctrl.sv
// Front-panel key controller: four debounced buttons step the waveform type,
// DDS tuning word and amplitude. Optional hold-to-repeat on the frequency keys: AUTOREPEAT_EN.

module wave_key_debounce #(
    parameter int DEBOUNCE_CYC = 20,
    parameter bit REPEAT       = 1'b0,
    parameter int HOLD_CYC     = 100,
    parameter int REPEAT_CYC   = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);
    // state        | meaning
    // RELEASED     | key up and stable
    // PRESS_WAIT   | key seen low, qualifying the press
    // PRESSED      | key down and stable (press already reported)
    // RELEASE_WAIT | key seen high, qualifying the release
    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    // The sample that moves us into a wait state already counts as the first stable one.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYC - 2);

    logic             sync_1, sync_2;
    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             qual;
    logic             rep_fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_raw;
            sync_2 <= sync_1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        qual      = 1'b0;
        case (state)
            ST_RELEASED: begin
                if (!sync_2) begin
                    state_nxt = ST_PRESS_WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_PRESS_WAIT: begin
                if (sync_2) begin
                    state_nxt = ST_RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ST_PRESSED;
                    qual      = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_PRESSED: begin
                if (sync_2) begin
                    state_nxt = ST_RELEASE_WAIT;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!sync_2) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ST_RELEASED;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef AUTOREPEAT_EN
    generate
        if (REPEAT) begin : g_repeat
            localparam int HOLD_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
            localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
            localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
            localparam logic [HOLD_W-1:0] REP_LOAD  = HOLD_W'(REPEAT_CYC - 1);

            logic [HOLD_W-1:0] hold_cnt;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_cnt <= HOLD_LOAD;
                end else if (state != ST_PRESSED) begin
                    hold_cnt <= HOLD_LOAD;
                end else if (!sync_2) begin
                    hold_cnt <= (hold_cnt == '0) ? REP_LOAD : hold_cnt - 1'b1;
                end
            end

            assign rep_fire = (state == ST_PRESSED) && !sync_2 && (hold_cnt == '0);
        end else begin : g_no_repeat
            assign rep_fire = 1'b0;
        end
    endgenerate
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RELEASED;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= qual | rep_fire;
        end
    end
endmodule

module wave_key_ctrl #(
    parameter int              DEBOUNCE_CYC = 20,
    parameter int              FW_W         = 32,
    parameter logic [FW_W-1:0] FSTEP        = FW_W'(4295),
    parameter logic [FW_W-1:0] FMIN         = FW_W'(4295),
    parameter logic [FW_W-1:0] FMAX         = FW_W'(429496730),
    parameter logic [FW_W-1:0] FRESET       = FW_W'(42950),
    parameter int              AMP_W        = 8,
    parameter int              HOLD_CYC     = 100,
    parameter int              REPEAT_CYC   = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       key,
    output logic [1:0]       wave_sel,
    output logic [FW_W-1:0]  freq_word,
    output logic [AMP_W-1:0] amp,
    output logic             cfg_upd
);
    localparam logic [AMP_W-1:0] AMP_MAX = {AMP_W{1'b1}};

    logic [3:0]       press;
    logic [1:0]       amp_lvl, amp_lvl_nxt;
    logic [1:0]       wave_nxt;
    logic [FW_W-1:0]  freq_nxt;
    logic [AMP_W-1:0] amp_nxt;
    logic [FW_W:0]    fw_up, fw_floor;
    logic             upd_nxt;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_key
            wave_key_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .REPEAT       (i == 1 || i == 2),
                .HOLD_CYC     (HOLD_CYC),
                .REPEAT_CYC   (REPEAT_CYC)
            ) u_deb (
                .clk     (clk),
                .rst_n   (rst_n),
                .key_raw (key[i]),
                .press   (press[i])
            );
        end
    endgenerate

    assign amp = AMP_MAX >> amp_lvl;

    always_comb begin
        wave_nxt    = press[0] ? wave_sel + 2'd1 : wave_sel;
        amp_lvl_nxt = press[3] ? amp_lvl + 2'd1 : amp_lvl;
        amp_nxt     = AMP_MAX >> amp_lvl_nxt;
        // One extra bit keeps both the raised word and the lower threshold from wrapping.
        fw_up    = {1'b0, freq_word} + {1'b0, FSTEP};
        fw_floor = {1'b0, FMIN} + {1'b0, FSTEP};
        freq_nxt = freq_word;
        if (press[1] && !press[2]) begin
            freq_nxt = (fw_up > {1'b0, FMAX}) ? FMAX : fw_up[FW_W-1:0];
        end else if (press[2] && !press[1]) begin
            freq_nxt = ({1'b0, freq_word} >= fw_floor) ? freq_word - FSTEP : FMIN;
        end
        upd_nxt = (wave_nxt != wave_sel) || (freq_nxt != freq_word) || (amp_nxt != amp);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wave_sel  <= 2'd0;
            freq_word <= FRESET;
            amp_lvl   <= 2'd0;
            cfg_upd   <= 1'b0;
        end else begin
            wave_sel  <= wave_nxt;
            freq_word <= freq_nxt;
            amp_lvl   <= amp_lvl_nxt;
            cfg_upd   <= upd_nxt;
        end
    end
endmodule

// File: tb/tb_wave_key_ctrl.sv
// Bench for wave_key_ctrl: press table plus glitch, hold and reset sequences,
// with expected updates queued at stimulus time and matched against cfg_upd.

module tb_wave_key_ctrl;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  key = 4'hF;
    logic [1:0]  wave_sel;
    logic [31:0] freq_word;
    logic [7:0]  amp;
    logic        cfg_upd;

    wave_key_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .FW_W         (32),
        .FSTEP        (32'd10),
        .FMIN         (32'd10),
        .FMAX         (32'd40),
        .FRESET       (32'd20),
        .AMP_W        (8),
        .HOLD_CYC     (8),
        .REPEAT_CYC   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key       (key),
        .wave_sel  (wave_sel),
        .freq_word (freq_word),
        .amp       (amp),
        .cfg_upd   (cfg_upd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          lo;
        int          hi;
        logic [1:0]  w;
        logic [31:0] f;
        logic [7:0]  a;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        int          hold;
        logic        upd;
        logic [1:0]  w;
        logic [31:0] f;
        logic [7:0]  a;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vt[20];
    int   n_vec = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_upd) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_upd: cycle %0d cfg_upd=1 wave_sel=%0d freq_word=%0d amp=%h, required cfg_upd=0",
                             cyc, wave_sel, freq_word, amp);
                end else begin
                    mon_e = sb.pop_front();
                    if (cyc < mon_e.lo || cyc > mon_e.hi || wave_sel !== mon_e.w ||
                        freq_word !== mon_e.f || amp !== mon_e.a) begin
                        n_err++;
                        $display("FAIL upd_check: cycle %0d wave_sel=%0d freq_word=%0d amp=%h, required cycle %0d..%0d wave_sel=%0d freq_word=%0d amp=%h",
                                 cyc, wave_sel, freq_word, amp, mon_e.lo, mon_e.hi, mon_e.w, mon_e.f, mon_e.a);
                    end
                end
            end else if (sb.size() > 0 && cyc > sb[0].hi) begin
                n_vec++;
                n_err++;
                mon_e = sb.pop_front();
                $display("FAIL late_upd: no cfg_upd by cycle %0d, required by cycle %0d with freq_word=%0d",
                         cyc, mon_e.hi, mon_e.f);
            end
        end
    end

    task automatic check_out(input string name, input logic [1:0] w, input logic [31:0] f,
                             input logic [7:0] a);
        n_vec++;
        if (wave_sel !== w || freq_word !== f || amp !== a || cfg_upd !== 1'b0) begin
            n_err++;
            $display("FAIL %s: wave_sel=%0d freq_word=%0d amp=%h cfg_upd=%b, required %0d %0d %h 0",
                     name, wave_sel, freq_word, amp, cfg_upd, w, f, a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d updates outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] mask, input int hold, input logic upd,
                         input logic [1:0] w, input logic [31:0] f, input logic [7:0] a);
        int t0;
        @(posedge clk);
        #1;
        t0  = cyc;
        key = ~mask;
        if (upd) sb.push_back('{t0 + DEB + 3, t0 + DEB + 3, w, f, a});
        repeat (hold) @(posedge clk);
        #1;
        key = 4'hF;
        drain();
    endtask

    initial begin
        int t0;
        vt[0]  = '{4'h1, 20, 1'b1, 2'd1, 32'd30, 8'hFF};
        vt[1]  = '{4'h1, 20, 1'b1, 2'd2, 32'd30, 8'hFF};
        vt[2]  = '{4'h1, 20, 1'b1, 2'd3, 32'd30, 8'hFF};
        vt[3]  = '{4'h1, 20, 1'b1, 2'd0, 32'd30, 8'hFF};
        vt[4]  = '{4'h2,  7, 1'b1, 2'd0, 32'd40, 8'hFF};
        vt[5]  = '{4'h2,  7, 1'b0, 2'd0, 32'd40, 8'hFF};
        vt[6]  = '{4'h6,  7, 1'b0, 2'd0, 32'd40, 8'hFF};
        vt[7]  = '{4'h9,  7, 1'b1, 2'd1, 32'd40, 8'h7F};
        vt[8]  = '{4'h8,  7, 1'b1, 2'd1, 32'd40, 8'h3F};
        vt[9]  = '{4'h8,  7, 1'b1, 2'd1, 32'd40, 8'h1F};
        vt[10] = '{4'h8,  7, 1'b1, 2'd1, 32'd40, 8'hFF};
        vt[11] = '{4'h4,  7, 1'b1, 2'd1, 32'd30, 8'hFF};
        vt[12] = '{4'h4,  7, 1'b1, 2'd1, 32'd20, 8'hFF};
        vt[13] = '{4'h4,  7, 1'b1, 2'd1, 32'd10, 8'hFF};
        vt[14] = '{4'h4,  7, 1'b0, 2'd1, 32'd10, 8'hFF};
        vt[15] = '{4'h6,  7, 1'b0, 2'd1, 32'd10, 8'hFF};
        vt[16] = '{4'h2,  7, 1'b1, 2'd1, 32'd20, 8'hFF};
        vt[17] = '{4'h7,  7, 1'b1, 2'd2, 32'd20, 8'hFF};
        vt[18] = '{4'h2,  7, 1'b1, 2'd2, 32'd30, 8'hFF};
        vt[19] = '{4'h2,  7, 1'b1, 2'd2, 32'd40, 8'hFF};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_out("reset_state", 2'd0, 32'd20, 8'hFF);
        repeat (30) @(posedge clk);
        #1;
        check_out("idle", 2'd0, 32'd20, 8'hFF);

        // key[1] glitch shorter than the debounce window, then a real press
        @(posedge clk);
        #1;
        key = 4'hD;
        repeat (3) @(posedge clk);
        #1;
        key = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        t0  = cyc;
        key = 4'hD;
        sb.push_back('{t0 + DEB + 3, t0 + DEB + 3, 2'd0, 32'd30, 8'hFF});
        repeat (8) @(posedge clk);
        #1;
        key = 4'hF;
        drain();
        check_out("glitch_then_press", 2'd0, 32'd30, 8'hFF);

        for (int i = 0; i < 20; i++) begin
            apply(vt[i].mask, vt[i].hold, vt[i].upd, vt[i].w, vt[i].f, vt[i].a);
            check_out($sformatf("vec%0d", i), vt[i].w, vt[i].f, vt[i].a);
        end

        // key[2] held 20 cycles from the top limit
        @(posedge clk);
        #1;
        t0  = cyc;
        key = 4'hB;
        sb.push_back('{t0 + DEB + 3, t0 + DEB + 3, 2'd2, 32'd30, 8'hFF});
`ifdef AUTOREPEAT_EN
        sb.push_back('{t0 + DEB + 11, t0 + DEB + 11, 2'd2, 32'd20, 8'hFF});
        sb.push_back('{t0 + DEB + 14, t0 + DEB + 14, 2'd2, 32'd10, 8'hFF});
`endif
        repeat (20) @(posedge clk);
        #1;
        key = 4'hF;
        drain();
`ifdef AUTOREPEAT_EN
        check_out("long_hold", 2'd2, 32'd10, 8'hFF);
`else
        check_out("long_hold", 2'd2, 32'd30, 8'hFF);
`endif

        // reset mid-debounce with key[3] held through it
        @(posedge clk);
        #1;
        key = 4'h7;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_out("in_reset", 2'd0, 32'd20, 8'hFF);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = cyc;
        sb.push_back('{t0 + 1 + DEB, t0 + 1 + DEB + 2, 2'd0, 32'd20, 8'h7F});
        repeat (20) @(posedge clk);
        #1;
        key = 4'hF;
        drain();
        check_out("after_reset_press", 2'd0, 32'd20, 8'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end
endmodule
